oc_tick_generator: RTL and testbench
====================================

Name: oc_tick_generator

Overview:
Parametrised successor to the fixed 1us/1ms/1s chip-status tick logic. A fractional phase accumulator generates a drift-free base tick from any integer ClockHz, including non-integer ClockHz/BaseHz ratios. A cascade of NumStages divide-by-StageDivide counters derives the slower ticks. Adds run-time enable, synchronous resync and a free-running uptime counter. Instantiated once per clock domain that needs time references, e.g. inside oc_chip_status.

Parameters:
ClockHz, 100_000_000, input clock frequency in Hz; must be >= BaseHz.
BaseHz, 1_000_000, frequency of tick[0] in Hz.
NumStages, 7, number of tick outputs; default gives 1us,10us,100us,1ms,10ms,100ms,1s.
StageDivide, 10, ratio between adjacent tick outputs; must be >= 2.
UptimeWidth, 48, width of the base-tick uptime counter.

Ports:
clock  input  1  single clock.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = run; 0 = hold accumulator and all counters.
resync  input  1  single-cycle pulse; restarts phase and all counters.
tick  output  NumStages  tick[k] is a one-cycle pulse at BaseHz/StageDivide^k.
uptime  output  UptimeWidth  count of base ticks since reset or resync.

Behaviour:
- Reset (async assert, clock-synchronous release): accumulator = 0, all stage counters = 0, tick = 0, uptime = 0.
- Accumulator:
  - Width AccW = $clog2(ClockHz+BaseHz)+1, unsigned.
  - Each enabled cycle, sum = acc + BaseHz.
  - If sum >= ClockHz: acc <= sum - ClockHz and baseHit = 1. Otherwise acc <= sum.
- Timing: tick[0] is registered from baseHit (one-cycle latency). First tick[0] is high in cycle N = ceil(ClockHz/BaseHz), counting cycle 1 as the first clock after reset release.
- Tick spacing: always floor or ceil of ClockHz/BaseHz cycles, i.e. jitter <= 1 clock period. Long-term average is exact, with zero cumulative drift.
- Stage k >= 1:
  - Counter cnt[k] runs 0..StageDivide-1 and advances only on a stage k-1 hit.
  - A stage k hit occurs when the stage k-1 hit coincides with cnt[k] == StageDivide-1; cnt[k] then wraps to 0.
  - All hits register in the same cycle, so tick[k] implies tick[k-1..0] high in that cycle.
- uptime increments by 1 in the cycle tick[0] is asserted and wraps modulo 2^UptimeWidth with no saturation.
- enable = 0:
  - acc, counters and uptime hold; tick = 0 from the next cycle.
  - Re-enable continues from the held phase; no tick is lost or duplicated.
- resync = 1:
  - Next edge sets acc = 0, all cnt = 0, uptime = 0, and tick = 0 for the cycle following.
  - Next tick[0] arrives N cycles after resync is sampled.
  - resync has priority over enable and over a coincident baseHit (that tick is suppressed).
- BaseHz == ClockHz: tick[0] is high every cycle.
- Elaboration $error if BaseHz > ClockHz, BaseHz == 0, or StageDivide < 2.

Decomposition:
- oclib_pkg: typedef tick_vec_t (NumStages-wide), localparam helper function for AccW.
- Sub-module oc_tick_divider: one cascade stage. Inputs clock, reset, clear, hitIn; output hitOut; parameter Divide. Instantiated in a generate loop NumStages-1 times.

Test Plan:
- ClockHz=100M, defaults, enable=1: tick[0] first at cycle 100 and every 100 cycles; tick[3] every 100_000 cycles; tick[6] every 100_000_000 cycles, coincident with tick[0..5].
- ClockHz=33_333_333: tick[0] intervals only 33 or 34 cycles; tick[3] intervals only 33_333 or 33_334 cycles; 1000 consecutive tick[0] span exactly 33_333 or 33_334 cycles; no drift over 40 tick[3] periods.
- enable low for 57 cycles mid-interval: no ticks while low; next tick[0] delayed by exactly 57 cycles; uptime unchanged during the gap.
- resync pulse 40 cycles after a tick[0] (ClockHz=100M): uptime = 0 next cycle; next tick[0] exactly 100 cycles after resync; resync coincident with a baseHit suppresses that tick.
- Async reset asserted mid-count (between clock edges): all outputs 0 immediately; first tick[0] N cycles after release; uptime restarts at 0 and reaches 1 on that tick.
- BaseHz=ClockHz=10M, StageDivide=4, NumStages=3: tick[0] is constant 1; tick[1] every 4 cycles; tick[2] every 16 cycles.

Source files
------------

// File: rtl/oclib_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | oclib_pkg: shared helpers for the oc timing blocks                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package oclib_pkg;

  // The accumulator must hold acc + BaseHz without overflow, with one spare bit.
  function automatic int acc_width(input longint unsigned clock_hz,
                                   input longint unsigned base_hz);
    return $clog2(clock_hz + base_hz) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oc_tick_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | oc_tick_divider: one divide-by-Divide stage of the tick cascade     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module oc_tick_divider #(
  parameter int unsigned Divide = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic hit_in,
  output logic hit_out
);

  localparam int CntW = (Divide >= 2) ? $clog2(Divide) : 1;
  localparam logic [CntW-1:0] Last = CntW'(Divide - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // hit_out is combinational so every stage of a coincident carry lands in one cycle.
  always_comb begin
    hit_out = hit_in && (cnt_q == Last);
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (hit_in) begin
      cnt_d = hit_out ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/oc_tick_generator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | oc_tick_generator: fractional base tick plus divided tick cascade   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module oc_tick_generator
  import oclib_pkg::*;
#(
  parameter int unsigned ClockHz     = 100_000_000,
  parameter int unsigned BaseHz      = 1_000_000,
  parameter int unsigned NumStages   = 7,
  parameter int unsigned StageDivide = 10,
  parameter int unsigned UptimeWidth = 48
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   resync,
  output logic [NumStages-1:0]   tick,
  output logic [UptimeWidth-1:0] uptime
);

  localparam int AccW = acc_width(64'(ClockHz), 64'(BaseHz));
  localparam logic [AccW-1:0] BaseInc  = AccW'(BaseHz);
  localparam logic [AccW-1:0] ClockLim = AccW'(ClockHz);

  if (BaseHz == 0 || BaseHz > ClockHz || StageDivide < 2) begin : g_bad_params
    $error("oc_tick_generator: need 0 < BaseHz <= ClockHz and StageDivide >= 2");
  end

  logic [AccW-1:0]        acc_q, acc_d, sum;
  logic                   base_hit, base_fire;
  logic [NumStages-1:0]   hit;
  logic [NumStages-1:0]   tick_q, tick_d;
  logic [UptimeWidth-1:0] uptime_q, uptime_d;

  // acc carries the fractional remainder, so the long-term rate is exact.
  always_comb begin
    sum       = acc_q + BaseInc;
    base_hit  = (sum >= ClockLim);
    base_fire = enable && !resync && base_hit;
    acc_d     = acc_q;
    uptime_d  = uptime_q;
    if (resync) begin
      acc_d    = '0;
      uptime_d = '0;
    end else if (enable) begin
      acc_d = base_hit ? (sum - ClockLim) : sum;
      if (base_hit) begin
        uptime_d = uptime_q + UptimeWidth'(1);
      end
    end
    tick_d = hit;
  end

  assign hit[0] = base_fire;

  for (genvar k = 1; k < NumStages; k++) begin : g_stage
    oc_tick_divider #(
      .Divide (StageDivide)
    ) u_div (
      .clock   (clock),
      .reset   (reset),
      .clear   (resync),
      .hit_in  (hit[k-1]),
      .hit_out (hit[k])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      tick_q   <= '0;
      uptime_q <= '0;
    end else begin
      acc_q    <= acc_d;
      tick_q   <= tick_d;
      uptime_q <= uptime_d;
    end
  end

  assign tick   = tick_q;
  assign uptime = uptime_q;

endmodule
`default_nettype wire

// File: tb/tb_oc_tick_generator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_oc_tick_generator: scoreboard bench against a rate-based model   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_oc_tick_generator;

  localparam int CA = 1000, BA = 30, DA = 3, WA = 8;
  localparam int CB = 10,   BB = 10, DB = 4, WB = 6;

  logic       clock = 1'b1;
  logic       reset, enable, resync;
  logic [2:0] tick_a, tick_b;
  logic [7:0] up_a;
  logic [5:0] up_b;

  typedef struct packed {
    logic [2:0] tick;
    logic [7:0] up;
  } exp_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  exp_t   last_a;
  exp_t   ea, eb;
  int     n_cmp = 0;
  int     n_bad = 0;
  longint n_en[2];
  longint m_tk[2];

  always #5 clock = ~clock;

  oc_tick_generator #(
    .ClockHz(CA), .BaseHz(BA), .NumStages(3), .StageDivide(DA), .UptimeWidth(WA)
  ) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .resync(resync),
    .tick(tick_a), .uptime(up_a)
  );

  oc_tick_generator #(
    .ClockHz(CB), .BaseHz(BB), .NumStages(3), .StageDivide(DB), .UptimeWidth(WB)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .resync(resync),
    .tick(tick_b), .uptime(up_b)
  );

  // Tick m (counted from reset/resync) falls on enabled cycle n when floor(n*B/C) steps;
  // stage k fires on every D^k-th base tick.
  function automatic exp_t model(input int id, input bit rst_i, input bit en_i, input bit rs_i);
    longint c, b, d, w;
    exp_t   e;
    c = (id == 0) ? CA : CB;
    b = (id == 0) ? BA : BB;
    d = (id == 0) ? DA : DB;
    w = (id == 0) ? WA : WB;
    e = '0;
    if (rst_i || rs_i) begin
      n_en[id] = 0;
      m_tk[id] = 0;
      return e;
    end
    if (en_i) begin
      n_en[id] = n_en[id] + 1;
      if ((n_en[id] * b) / c != ((n_en[id] - 1) * b) / c) begin
        m_tk[id]  = m_tk[id] + 1;
        e.tick[0] = 1'b1;
        e.tick[1] = (m_tk[id] % d == 0);
        e.tick[2] = (m_tk[id] % (d * d) == 0);
      end
    end
    e.up = 8'(m_tk[id] % (longint'(1) << w));
    return e;
  endfunction

  function automatic bit will_hit_a();
    return ((n_en[0] + 1) * BA) / CA != (n_en[0] * BA) / CA;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit en, input bit rs, input bit rst_lvl);
    @(negedge clock);
    enable = en;
    resync = rs;
    reset  = rst_lvl;
    last_a = model(0, rst_lvl, en, rs);
    q_a.push_back(last_a);
    q_b.push_back(model(1, rst_lvl, en, rs));
  endtask

  always @(posedge clock) begin
    #1;
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      check("a_tick", {5'd0, tick_a}, {5'd0, ea.tick});
      check("a_uptime", up_a, ea.up);
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      check("b_tick", {5'd0, tick_b}, {5'd0, eb.tick});
      check("b_uptime", {2'b00, up_b}, eb.up);
    end
  end

  initial begin
    bit en, rs;
    reset  = 1'b1;
    enable = 1'b0;
    resync = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    repeat (3500) cycle(1'b1, 1'b0, 1'b0);
    repeat (57) cycle(1'b0, 1'b0, 1'b0);
    repeat (200) cycle(1'b1, 1'b0, 1'b0);

    // resync 40 cycles after a base tick
    for (int i = 0; i < 100 && !last_a.tick[0]; i++) cycle(1'b1, 1'b0, 1'b0);
    repeat (39) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (100) cycle(1'b1, 1'b0, 1'b0);

    // resync landing on the cycle that would have produced a tick
    for (int i = 0; i < 100 && !will_hit_a(); i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (60) cycle(1'b1, 1'b0, 1'b0);

    repeat (12000) begin
      en = ($urandom_range(0, 7) != 0);
      rs = ($urandom_range(0, 399) == 0);
      cycle(en, rs, 1'b0);
    end

    // asynchronous reset asserted between clock edges
    @(negedge clock);
    enable = 1'b1;
    resync = 1'b0;
    q_a.push_back(model(0, 1'b1, 1'b1, 1'b0));
    q_b.push_back(model(1, 1'b1, 1'b1, 1'b0));
    #2 reset = 1'b1;
    #1;
    check("async_rst_tick_a", {5'd0, tick_a}, 8'd0);
    check("async_rst_up_a", up_a, 8'd0);
    check("async_rst_tick_b", {5'd0, tick_b}, 8'd0);
    check("async_rst_up_b", {2'b00, up_b}, 8'd0);
    repeat (2) cycle(1'b1, 1'b0, 1'b1);
    repeat (2000) cycle(1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    check("queue_drained", 8'(q_a.size() + q_b.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
